// File: rtl/reg_monitor_uart_tx.sv
// Register-monitor stream sampler: captures registers 0..31 in order, one per
// 6-byte 8N1 UART frame (sync, addr, data MSB..LSB), sent on a single tx line.
module reg_monitor_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] reg_data,
  input  logic [4:0]  reg_addr,
  input  logic        reg_valid,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'd5;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [2:0]       byte_idx, byte_idx_n;
  logic [7:0]       shift, shift_n;
  logic [4:0]       addr_q, addr_q_n;
  logic [31:0]      data_q, data_q_n;
  logic [4:0]       next_idx, next_idx_n;
  logic             tx_n, busy_n, frame_done_n;
  logic             bit_end;
  logic [2:0]       byte_inc;

  // Byte k of the frame built from the latched sample.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [4:0]  a,
                                            input logic [31:0] d);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {3'b000, a};
      3'd2:    b = d[31:24];
      3'd3:    b = d[23:16];
      3'd4:    b = d[15:8];
      default: b = d[7:0];
    endcase
    return b;
  endfunction

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign byte_inc = byte_idx + 3'd1;

  // Next-state and next-output logic; tx is derived from the next state so the
  // registered line changes exactly on bit boundaries.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_cnt_n    = bit_cnt;
    byte_idx_n   = byte_idx;
    shift_n      = shift;
    addr_q_n     = addr_q;
    data_q_n     = data_q;
    next_idx_n   = next_idx;
    frame_done_n = 1'b0;
    tx_n         = 1'b1;
    busy_n       = 1'b0;

    if (state != S_IDLE) begin
      baud_cnt_n = bit_end ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (reg_valid && (reg_addr == next_idx)) begin
          addr_q_n   = reg_addr;
          data_q_n   = reg_data;
          next_idx_n = next_idx + 5'd1;
          byte_idx_n = 3'd0;
          bit_cnt_n  = 3'd0;
          shift_n    = SYNC_BYTE;
          state_n    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_n = 3'd0;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_cnt == LAST_BIT) begin
            state_n = S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            state_n      = S_IDLE;
            frame_done_n = 1'b1;
          end else begin
            byte_idx_n = byte_inc;
            shift_n    = frame_byte(byte_inc, addr_q, data_q);
            state_n    = S_START;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      byte_idx   <= 3'd0;
      shift      <= 8'd0;
      addr_q     <= 5'd0;
      data_q     <= 32'd0;
      next_idx   <= 5'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      byte_idx   <= byte_idx_n;
      shift      <= shift_n;
      addr_q     <= addr_q_n;
      data_q     <= data_q_n;
      next_idx   <= next_idx_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
